ps_pad_responder: RTL
=====================

// Module: ps_pad_responder
// PURPOSE
//  Device-side (pad) end of the DualShock/PS serial link: emulates a controller answering a host poll.
//  Oversamples host CLK/SEL/CMD on the system clock and shifts response bytes out on DAT, LSB first.
//  Generates the ACK pulse after each byte and captures the host vibration bytes.
//  Used for loopback verification of the host-side controller logic and for pad emulation from UART/test logic.
// PARAMETERS
//  ACK_DELAY  20  clk cycles from a byte's 8th CLK rising edge to ps_ack_n falling; range 1..255
//  ACK_WIDTH  25  clk cycles ps_ack_n is held low; range 1..255
// PORTS
//  clk          in   1   system clock; every ps_* input is asynchronous to it
//  reset        in   1   asynchronous, active-high reset
//  ps_clk       in   1   host serial clock; idles high
//  ps_sel_n     in   1   host select, active low; frames one packet
//  ps_cmd       in   1   host command data (host MOSI)
//  ps_dat       out  1   pad response data (host MISO); idles 1
//  ps_ack_n     out  1   pad acknowledge, active low
//  btn_n        in   16  buttons, active low; [7:0]=resp byte3, [15:8]=resp byte4
//  stick        in   32  [7:0]=RX [15:8]=RY [23:16]=LX [31:24]=LY (bytes 5..8)
//  vib_small    out  8   host byte3 of the last completed 0x42 packet
//  vib_large    out  8   host byte4 of the last completed 0x42 packet
//  packet_done  out  1   1-cycle pulse when a full valid packet completes
//  busy         out  1   high from SEL fall until return to IDLE
// BEHAVIOUR
//  - Reset: ps_dat=1, ps_ack_n=1, vib_*=0, packet_done=0, busy=0, FSM=IDLE, armed=0.
//  - ps_clk, ps_sel_n, ps_cmd go through 2-FF synchronisers; edges are detected on the synced copies.
//  - armed is set once synced SEL is seen high; a SEL-low already present at reset release is ignored.
//  - IDLE: when armed and synced SEL falls, snapshot btn_n/stick, set byte_idx=0 and bit_idx=0, go to SHIFT.
//  - SHIFT: on each CLK fall, drive ps_dat=resp[byte_idx][bit_idx] within 3 clk of the raw edge.
//    On each CLK rise, shift ps_cmd into cmd_sr and increment bit_idx (3-bit, wraps 7->0).
//  - Byte end is the 8th rise. Host byte0 must equal 0x01, else go to IGNORE (no ACK).
//    If host byte1 != 0x42, go to IGNORE after byte1, with no ACK for byte1.
//  - Response bytes: 0xFF, ID, 0x5A, btn_n[7:0], btn_n[15:8], then stick bytes 5..8 (analog only).
//  - Non-final byte end -> ACK_WAIT (ACK_DELAY clk) -> ACK_PULSE (ps_ack_n=0 for ACK_WIDTH) -> SHIFT,
//    with byte_idx++.
//  - A CLK fall during ACK_WAIT or ACK_PULSE releases ps_ack_n the same cycle, enters SHIFT, and serves
//    that fall as bit0 of the next byte.
//  - Final byte end: no ACK. Latch vib_small/vib_large from the captured host bytes 3/4, pulse
//    packet_done, go to IGNORE.
//  - IGNORE: ps_dat=1, ps_ack_n=1, wait for synced SEL high, then IDLE.
//  - Synced SEL rising in any state aborts: ps_dat=1 and ps_ack_n=1 next cycle, IDLE, no packet_done,
//    vib_* unchanged.
//  - Simultaneous SEL rise and CLK edge: SEL wins.
//  - Reset asserted mid-packet: outputs return to reset values immediately (async) and the rest of the
//    packet is ignored via armed.
//  - ps_dat is driven 1 in IDLE/IGNORE and between packets; no tristate, board logic makes it open-drain.
//  - busy=0 only in IDLE.
// CONFIGURATION
//  PS_PAD_ANALOG_EN defined: ID=0x73; 9-byte packet; final byte is byte 8 (LY).
//  PS_PAD_ANALOG_EN undefined: ID=0x41; 5-byte packet; final byte is byte 4; stick ignored.
//  Timing, ACK and vibration behaviour are identical in both builds.
// TESTING
//  1. Host 01 42 00 00 00 (digital build) with btn_n=16'hFFFE -> DAT bytes FF 41 5A FE FF;
//     4 ACKs of ACK_WIDTH clk; packet_done=1 once; busy falls after SEL high.
//  2. Analog build, host 01 42 00 40 FF 00 00 00 00, stick=32'h80_7F_10_F0 ->
//     DAT FF 73 5A <btn> <btn> F0 10 7F 80; vib_small=40, vib_large=FF after the last byte; 8 ACKs.
//  3. Host byte0=0x81 -> no ACK, ps_dat stays 1 for the whole packet, no packet_done, vib_* unchanged.
//  4. Host 01 43 ... -> ACK after byte0 only; DAT=1 from byte2 on; no packet_done.
//  5. SEL raised after 3 bits of byte3 -> ps_dat=1 and ps_ack_n=1 within 3 clk; vib_* unchanged;
//     the next full packet responds normally.
//  6. Reset pulsed mid-byte2 with SEL held low -> outputs at reset values, no response until SEL
//     goes high and then low again.

Source files
------------

// File: rtl/ps_pad_responder.sv
// ps_pad_responder: device (pad) end of the PS/DualShock serial link.
// Answers a host poll: oversamples ps_clk/ps_sel_n/ps_cmd on clk, shifts the
// response out on ps_dat LSB first, pulses ps_ack_n after each non-final byte
// and captures the host vibration bytes (host bytes 3/4 of a 0x42 poll).
// Ports: clk, reset (async, active high); ps_clk/ps_sel_n/ps_cmd host link in;
//   ps_dat/ps_ack_n pad link out; btn_n[15:0], stick[31:0] pad state in;
//   vib_small/vib_large, packet_done, busy status out.
// Build option: PS_PAD_ANALOG_EN -> analog pad (ID 0x73, 9-byte packet,
//   stick bytes 5..8); undefined -> digital pad (ID 0x41, 5-byte packet).
module ps_pad_responder #(
   parameter int ACK_DELAY = 20,
   parameter int ACK_WIDTH = 25
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ps_clk,
   input  logic        ps_sel_n,
   input  logic        ps_cmd,
   output logic        ps_dat,
   output logic        ps_ack_n,
   input  logic [15:0] btn_n,
   input  logic [31:0] stick,
   output logic [7:0]  vib_small,
   output logic [7:0]  vib_large,
   output logic        packet_done,
   output logic        busy
);

`ifdef PS_PAD_ANALOG_EN
   localparam logic [7:0] PAD_ID    = 8'h73;
   localparam logic [3:0] LAST_BYTE = 4'd8;
`else
   localparam logic [7:0] PAD_ID    = 8'h41;
   localparam logic [3:0] LAST_BYTE = 4'd4;
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_SHIFT,
      S_ACK_WAIT,
      S_ACK_PULSE,
      S_IGNORE
   } state_t;

   state_t      state, state_n;
   logic        clk_m, clk_s, clk_d;
   logic        sel_m, sel_s, sel_d;
   logic        cmd_m, cmd_s;
   logic        armed;
   logic        clk_rise, clk_fall, sel_rise, sel_fall;
   logic [3:0]  byte_idx, byte_idx_n;
   logic [2:0]  bit_idx, bit_idx_n;
   logic [7:0]  cmd_sr, cmd_sr_n;
   logic [7:0]  rx_byte;
   logic [7:0]  cnt, cnt_n;
   logic [7:0]  b3, b3_n, b4, b4_n;
   logic [7:0]  vs_n, vl_n;
   logic        dat_n, ack_n_n, done_n;
   logic        load;
   logic [15:0] btn_q;
   logic [7:0]  resp_byte;

`ifdef PS_PAD_ANALOG_EN
   logic [31:0] stick_q;
`else
   logic        unused_stick;
   assign unused_stick = ^stick;
`endif

   // Synchronisers. The clk copies reset high (idle level); the SEL copies
   // reset low so a SEL already low at reset release never arms the pad.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clk_m <= 1'b1;
         clk_s <= 1'b1;
         clk_d <= 1'b1;
         sel_m <= 1'b0;
         sel_s <= 1'b0;
         sel_d <= 1'b0;
         cmd_m <= 1'b0;
         cmd_s <= 1'b0;
         armed <= 1'b0;
      end else begin
         clk_m <= ps_clk;
         clk_s <= clk_m;
         clk_d <= clk_s;
         sel_m <= ps_sel_n;
         sel_s <= sel_m;
         sel_d <= sel_s;
         cmd_m <= ps_cmd;
         cmd_s <= cmd_m;
         armed <= armed | sel_s;
      end
   end

   assign clk_rise = clk_s & ~clk_d;
   assign clk_fall = ~clk_s & clk_d;
   assign sel_rise = sel_s & ~sel_d;
   assign sel_fall = ~sel_s & sel_d;
   assign rx_byte  = {cmd_s, cmd_sr[7:1]};
   assign busy     = (state != S_IDLE);

   always_comb begin
      case (byte_idx)
         4'd1:    resp_byte = PAD_ID;
         4'd2:    resp_byte = 8'h5A;
         4'd3:    resp_byte = btn_q[7:0];
         4'd4:    resp_byte = btn_q[15:8];
`ifdef PS_PAD_ANALOG_EN
         4'd5:    resp_byte = stick_q[7:0];
         4'd6:    resp_byte = stick_q[15:8];
         4'd7:    resp_byte = stick_q[23:16];
         4'd8:    resp_byte = stick_q[31:24];
`endif
         default: resp_byte = 8'hFF;
      endcase
   end

   always_comb begin
      state_n    = state;
      byte_idx_n = byte_idx;
      bit_idx_n  = bit_idx;
      cmd_sr_n   = cmd_sr;
      cnt_n      = cnt;
      b3_n       = b3;
      b4_n       = b4;
      vs_n       = vib_small;
      vl_n       = vib_large;
      dat_n      = ps_dat;
      ack_n_n    = ps_ack_n;
      done_n     = 1'b0;
      load       = 1'b0;
      if (sel_rise) begin
         // SEL release aborts whatever is in flight, even on a CLK edge.
         state_n = S_IDLE;
         dat_n   = 1'b1;
         ack_n_n = 1'b1;
      end else begin
         case (state)
            S_IDLE: begin
               dat_n   = 1'b1;
               ack_n_n = 1'b1;
               if (armed && sel_fall) begin
                  state_n    = S_SHIFT;
                  byte_idx_n = 4'd0;
                  bit_idx_n  = 3'd0;
                  load       = 1'b1;
               end
            end
            S_SHIFT: begin
               if (clk_fall) begin
                  dat_n = resp_byte[bit_idx];
               end else if (clk_rise) begin
                  cmd_sr_n  = rx_byte;
                  bit_idx_n = bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
                     if ((byte_idx == 4'd0 && rx_byte != 8'h01) ||
                         (byte_idx == 4'd1 && rx_byte != 8'h42)) begin
                        state_n = S_IGNORE;
                        dat_n   = 1'b1;
                     end else if (byte_idx == LAST_BYTE) begin
                        state_n = S_IGNORE;
                        dat_n   = 1'b1;
                        done_n  = 1'b1;
                        vs_n    = b3;
                        vl_n    = (byte_idx == 4'd4) ? rx_byte : b4;
                     end else begin
                        state_n    = S_ACK_WAIT;
                        cnt_n      = 8'(ACK_DELAY - 1);
                        byte_idx_n = byte_idx + 4'd1;
                        if (byte_idx == 4'd3) b3_n = rx_byte;
                        if (byte_idx == 4'd4) b4_n = rx_byte;
                     end
                  end
               end
            end
            S_ACK_WAIT: begin
               if (clk_fall) begin
                  // Host did not wait for ACK: serve bit0 of the next byte.
                  state_n = S_SHIFT;
                  ack_n_n = 1'b1;
                  dat_n   = resp_byte[bit_idx];
               end else if (cnt == 8'd0) begin
                  state_n = S_ACK_PULSE;
                  ack_n_n = 1'b0;
                  cnt_n   = 8'(ACK_WIDTH - 1);
               end else begin
                  cnt_n = cnt - 8'd1;
               end
            end
            S_ACK_PULSE: begin
               if (clk_fall) begin
                  state_n = S_SHIFT;
                  ack_n_n = 1'b1;
                  dat_n   = resp_byte[bit_idx];
               end else if (cnt == 8'd0) begin
                  state_n = S_SHIFT;
                  ack_n_n = 1'b1;
               end else begin
                  cnt_n = cnt - 8'd1;
               end
            end
            S_IGNORE: begin
               dat_n   = 1'b1;
               ack_n_n = 1'b1;
               if (sel_s) state_n = S_IDLE;
            end
            default: begin
               state_n = S_IDLE;
               dat_n   = 1'b1;
               ack_n_n = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         byte_idx    <= 4'd0;
         bit_idx     <= 3'd0;
         cmd_sr      <= 8'd0;
         cnt         <= 8'd0;
         b3          <= 8'd0;
         b4          <= 8'd0;
         vib_small   <= 8'd0;
         vib_large   <= 8'd0;
         ps_dat      <= 1'b1;
         ps_ack_n    <= 1'b1;
         packet_done <= 1'b0;
         btn_q       <= 16'hFFFF;
      end else begin
         state       <= state_n;
         byte_idx    <= byte_idx_n;
         bit_idx     <= bit_idx_n;
         cmd_sr      <= cmd_sr_n;
         cnt         <= cnt_n;
         b3          <= b3_n;
         b4          <= b4_n;
         vib_small   <= vs_n;
         vib_large   <= vl_n;
         ps_dat      <= dat_n;
         ps_ack_n    <= ack_n_n;
         packet_done <= done_n;
         if (load) btn_q <= btn_n;
      end
   end

`ifdef PS_PAD_ANALOG_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)     stick_q <= 32'd0;
      else if (load) stick_q <= stick;
   end
`endif

endmodule
